aes_inv_round_iter: RTL and testbench
=====================================

Name: aes_inv_round_iter

Overview:
- Iterative AES inverse cipher (decryption) datapath: one inverse round per clock.
- Consumes round keys in descending order from the key-schedule store through a combinational read port.
- Mirrors the encryption round engine and pairs with the shiftrows/subbytes/mixcolumns sublayers in decrypt mode (enc=0).
- Sits between the crypto-engine register interface and the round-key RAM inside the HW-RoT AES unit.

Parameters:
- NR, 10, number of rounds. Legal values: 10, 12, 14. The key store must hold NR+1 round keys.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to decrypt data_in. Accepted only in IDLE.
- data_in  in  128  ciphertext, byte 0 in [127:120]. Sampled on the accepting edge.
- rk_addr  out  4  round-key index. Combinational from FSM/counter.
- rk_data  in  128  round key at rk_addr. Combinational read, same cycle.
- busy  out  1  high while a block is in flight.
- data_out  out  128  plaintext. Registered; holds until the next completion.
- valid  out  1  one-cycle pulse when data_out updates.

Behaviour:
- Reset (async, any time, including mid-block): FSM -> IDLE, round counter -> 0, state reg -> 0, data_out -> 0, busy -> 0, valid -> 0. A block in flight is discarded and produces no valid.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - rk_addr = NR.
  - If start=1 on edge T: state <= data_in ^ rk_data (initial AddRoundKey), rnd <= NR-1, go to ROUND.
- ROUND:
  - rk_addr = rnd.
  - Each edge: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - If rnd==1, go to FINAL; otherwise rnd <= rnd-1.
- FINAL:
  - rk_addr = 0.
  - Edge: data_out <= InvSubBytes(InvShiftRows(state)) ^ rk_data; valid <= 1; go to IDLE.
- Sublayer definitions:
  - InvShiftRows: column-major byte order b0..b15 maps to {b0,b13,b10,b7,b4,b1,b14,b11,b8,b5,b2,b15,b12,b9,b6,b3}.
  - InvSubBytes: 16 instances of the existing sbox with enc=0.
  - InvMixColumns: per column, GF(2^8) multiplies by {0e,0b,0d,09}, built from xtime chains. Reduction polynomial 0x11B.
- Latency, start accepted at edge T:
  - busy = 1 from T+1 through T+NR (NR cycles).
  - valid = 1 in cycle T+NR+1 only; data_out is valid from then on.
  - NR=10 gives 11 cycles start-to-valid.
- start while busy: ignored, with no queueing and no effect on the current block.
- start in the same cycle valid pulses: FSM is already in IDLE, so it is accepted. Back-to-back throughput is one block per NR+1 cycles.
- data_in and rk_data are don't-care outside their sampling cycles.
- rk_addr never exceeds NR and never wraps. The counter is 4 bits and saturates its decrement at 1 inside ROUND.

Test Plan:
- FIPS-197 App. B: bench model supplies round keys for key 2b7e151628aed2a6abf7158809cf4f3c; data_in = 3925841d02dc09fbdc118597196a0b32, start at T -> valid at T+11, data_out = 3243f6a8885a308d313198a2e0370734.
- FIPS-197 App. C.1: key 000102…0f, data_in = 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out = 00112233445566778899aabbccddeeff. Check rk_addr sequence 10,9,…,1,0 on consecutive cycles from T.
- Back-to-back: restart in the valid cycle with the C.1 vector after the B vector -> two correct results, 11 cycles apart. busy is low only in the restart cycle.
- start pulsed at T+3 and T+7 during a block -> ignored; result and timing unchanged; exactly one valid.
- rst asserted asynchronously at T+5 for a half cycle -> busy, valid, data_out = 0 immediately; no valid for the aborted block; a new start then decrypts correctly.
- NR=14: App. C.3 key 000102…1f, data_in = 8ea2b7ca516745bfeafc49904b496089 -> valid at T+15, data_out = 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_inv_round_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_round_iter
// Description : Iterative AES inverse cipher. Runs one inverse round per clock
//               and reads round keys in descending order through a
//               combinational key-store read port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   decrypt request, accepted only when idle
//   data_in  in   128-bit ciphertext (byte 0 in [127:120])
//   rk_addr  out  round-key index presented to the key store
//   rk_data  in   round key at rk_addr (same-cycle read)
//   busy     out  high while a block is in flight
//   data_out out  128-bit plaintext, held until the next completion
//   valid    out  one-cycle pulse when data_out updates
// ============================================================================
module aes_inv_round_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         busy,
  output logic [127:0] data_out,
  output logic         valid
);

  localparam logic [3:0] NR_ADDR = 4'(NR);
  localparam logic [3:0] NR_M1   = 4'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t       fsm;
  logic [3:0]   rnd;
  logic [127:0] st;

  logic [127:0] isr_w;   // InvShiftRows(st)
  logic [127:0] isb_w;   // InvSubBytes(isr_w)
  logic [127:0] ark_w;   // isb_w ^ rk_data
  logic [127:0] imc_w;   // InvMixColumns(ark_w)

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte i sits at row i%4 of column i/4; InvShiftRows pulls row r from the
  // column r positions to the left (mod 4).
  generate
    for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int ROW = i % 4;
      localparam int COL = i / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr_w[127-8*i -: 8] = st[127-8*SRC -: 8];
      assign isb_w[127-8*i -: 8] = inv_sbox(isr_w[127-8*i -: 8]);
    end
  endgenerate

  assign ark_w = isb_w ^ rk_data;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign imc_w[127-32*c -: 32] = inv_mix_col(ark_w[127-32*c -: 32]);
    end
  endgenerate

  always_comb begin
    rk_addr = NR_ADDR;
    case (fsm)
      S_IDLE:  rk_addr = NR_ADDR;
      S_ROUND: rk_addr = rnd;
      S_FINAL: rk_addr = 4'd0;
      default: rk_addr = NR_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= S_IDLE;
      rnd      <= 4'd0;
      st       <= 128'd0;
      data_out <= 128'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            st   <= data_in ^ rk_data;
            rnd  <= NR_M1;
            busy <= 1'b1;
            fsm  <= S_ROUND;
          end
        end
        S_ROUND: begin
          st <= imc_w;
          // Counter parks at 1 on the way into FINAL instead of wrapping.
          if (rnd == 4'd1) fsm <= S_FINAL;
          else             rnd <= rnd - 4'd1;
        end
        S_FINAL: begin
          data_out <= ark_w;
          valid    <= 1'b1;
          busy     <= 1'b0;
          fsm      <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_round_iter
// Description : Directed bench for aes_inv_round_iter using FIPS-197 vectors,
//               with NR=10 and NR=14 instances and bench-side key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_round_iter;

  logic         clk;
  logic         rst;

  logic         start10, busy10, valid10;
  logic [127:0] data_in10, rk_data10, data_out10;
  logic [3:0]   rk_addr10;

  logic         start14, busy14, valid14;
  logic [127:0] data_in14, rk_data14, data_out14;
  logic [3:0]   rk_addr14;

  logic [127:0] key_b  [0:15];
  logic [127:0] key_c  [0:15];
  logic [127:0] key_14 [0:15];
  logic         ksel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_round_iter #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .data_in(data_in10),
    .rk_addr(rk_addr10), .rk_data(rk_data10), .busy(busy10),
    .data_out(data_out10), .valid(valid10)
  );

  aes_inv_round_iter #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .start(start14), .data_in(data_in14),
    .rk_addr(rk_addr14), .rk_data(rk_data14), .busy(busy14),
    .data_out(data_out14), .valid(valid14)
  );

  assign rk_data10 = ksel ? key_c[rk_addr10] : key_b[rk_addr10];
  assign rk_data14 = key_14[rk_addr14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- key expansion model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // dest: 0 -> key_b, 1 -> key_c, 2 -> key_14
  task automatic expand(input logic [255:0] key, input int nk, input int nr, input int dest);
    logic [31:0] w [0:59];
    logic [31:0] t;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'd0};
      else if (nk > 6 && i % nk == 4) t = subword(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (dest == 0)      key_b[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else if (dest == 1) key_c[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else                key_14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Runs one block on the NR=10 instance; caller is at a point away from a
  // clock edge. Returns #1 after the edge that raised valid.
  task automatic do_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                          input logic sel, input bit chk_seq, input bit noise);
    int          cyc;
    int          nbusy;
    int          ntail;
    logic [43:0] seq;
    check({tag, "_busy_at_start"}, {127'd0, busy10}, 128'd0);
    ksel      = sel;
    data_in10 = ct;
    start10   = 1'b1;
    seq       = {40'd0, rk_addr10};
    nbusy     = 0;
    @(posedge clk); #1;
    start10   = 1'b0;
    data_in10 = {$urandom, $urandom, $urandom, $urandom};
    cyc       = 1;
    while (!valid10 && cyc < 20) begin
      seq = {seq[39:0], rk_addr10};
      if (busy10) nbusy++;
      @(posedge clk); #1;
      start10 = 1'b0;
      cyc++;
      if (noise && (cyc == 3 || cyc == 7)) begin
        start10   = 1'b1;
        data_in10 = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check({tag, "_latency"}, 128'(cyc), 128'd11);
    check({tag, "_busy_cycles"}, 128'(nbusy), 128'd10);
    check({tag, "_busy_in_valid"}, {127'd0, busy10}, 128'd0);
    check({tag, "_data_out"}, data_out10, pt);
    if (chk_seq) check({tag, "_rk_addr_seq"}, {84'd0, seq}, {84'd0, 44'hA9876543210});
    if (noise) begin
      ntail = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (valid10) ntail++;
      end
      check({tag, "_extra_valid"}, 128'(ntail), 128'd0);
      check({tag, "_data_hold"}, data_out10, pt);
    end
  endtask

  initial begin
    int cyc;
    int nv;
    rst       = 1'b1;
    start10   = 1'b0;
    start14   = 1'b0;
    data_in10 = '0;
    data_in14 = '0;
    ksel      = 1'b0;
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 4, 10, 0);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'd0}, 4, 10, 1);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 2);

    #12;
    check("rst_busy",      {127'd0, busy10},  128'd0);
    check("rst_valid",     {127'd0, valid10}, 128'd0);
    check("rst_data_out",  data_out10,        128'd0);
    check("rst_rk_addr",   {124'd0, rk_addr10}, 128'd10);
    check("rst_rk_addr14", {124'd0, rk_addr14}, 128'd14);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 B, then back-to-back restart with C.1 in the valid cycle.
    do_block("fips_b", CT_B, PT_B, 1'b0, 1'b0, 1'b0);
    do_block("fips_c1", CT_C1, PT_C, 1'b1, 1'b1, 1'b0);
    // start pulses during a block must be ignored.
    do_block("noise", CT_B, PT_B, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-block.
    @(negedge clk);
    ksel      = 1'b1;
    data_in10 = CT_C1;
    start10   = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy",     {127'd0, busy10},  128'd0);
    check("arst_valid",    {127'd0, valid10}, 128'd0);
    check("arst_data_out", data_out10,        128'd0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid10) nv++;
    end
    check("arst_no_valid", 128'(nv), 128'd0);
    @(negedge clk);
    do_block("after_rst", CT_C1, PT_C, 1'b1, 1'b0, 1'b0);

    // NR=14, FIPS-197 C.3.
    @(negedge clk);
    data_in14 = CT_C3;
    start14   = 1'b1;
    @(posedge clk); #1;
    start14 = 1'b0;
    cyc = 1;
    while (!valid14 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("nr14_latency",  128'(cyc), 128'd15);
    check("nr14_data_out", data_out14, PT_C);
    check("nr14_busy_in_valid", {127'd0, busy14}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
